// File: rtl/axi_lite_regs.sv
// AXI-Lite responder terminating the link in a bank of R/W (byte-strobed) and RO registers.
// Write address and data are held independently and committed together once B is free.
module axi_lite_regs #(
  parameter int unsigned                         ADDR_WIDTH = 12,
  parameter int unsigned                         DATA_WIDTH = 32,
  parameter int unsigned                         NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]                 RO_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]      RESET_VAL  = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  // Write address channel
  input  logic                           aw_valid,
  output logic                           aw_ready,
  input  logic [ADDR_WIDTH-1:0]          aw_addr,
  input  logic [2:0]                     aw_prot,
  // Write data channel
  input  logic                           w_valid,
  output logic                           w_ready,
  input  logic [DATA_WIDTH-1:0]          w_data,
  input  logic [DATA_WIDTH/8-1:0]        w_strb,
  // Write response channel
  output logic                           b_valid,
  input  logic                           b_ready,
  output logic [1:0]                     b_resp,
  // Read address channel
  input  logic                           ar_valid,
  output logic                           ar_ready,
  input  logic [ADDR_WIDTH-1:0]          ar_addr,
  input  logic [2:0]                     ar_prot,
  // Read data channel
  output logic                           r_valid,
  input  logic                           r_ready,
  output logic [DATA_WIDTH-1:0]          r_data,
  output logic [1:0]                     r_resp,
  // Register side
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB   = (DATA_WIDTH == 64) ? 3 : 2;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  logic                  aw_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic                  w_held;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [NUM_REGS-1:0]   wr_sel;
  logic                  wr_match;
  logic                  wr_ro;
  logic [1:0]            wr_resp;
  logic                  rd_match;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0]            rd_resp;

  logic unused_prot;
  assign unused_prot = ^{aw_prot, ar_prot};

  assign aw_ready = !aw_held;
  assign w_ready  = !w_held;
  assign ar_ready = !r_valid;
  assign commit   = aw_held && w_held && !b_valid;

  assign wr_idx = aw_addr_q >> ADDR_LSB;
  assign rd_idx = ar_addr >> ADDR_LSB;

  // Write target decode; an out-of-range index matches no register.
  always_comb begin
    wr_sel   = '0;
    wr_match = 1'b0;
    wr_ro    = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == ADDR_WIDTH'(i)) begin
        wr_match  = 1'b1;
        wr_ro     = RO_MASK[i];
        wr_sel[i] = !RO_MASK[i];
      end
    end
    if (!wr_match) begin
      wr_resp = RespDecErr;
    end else if (wr_ro) begin
      wr_resp = RespSlvErr;
    end else begin
      wr_resp = RespOkay;
    end
  end

  // Read mux sees pre-commit register values.
  always_comb begin
    rd_match = 1'b0;
    rd_data  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == ADDR_WIDTH'(i)) begin
        rd_match = 1'b1;
        rd_data  = RO_MASK[i] ? ro_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
      end
    end
    rd_resp = rd_match ? RespOkay : RespDecErr;
  end

  // RO entries are never written, so they stay zero and read back as zero on reg_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RO_MASK[i] ? '0 : RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          for (int k = 0; k < STRB_WIDTH; k++) begin
            if (w_strb_q[k]) begin
              regs_q[i][k*8 +: 8] <= w_data_q[k*8 +: 8];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held   <= 1'b0;
      aw_addr_q <= '0;
      w_held    <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid   <= 1'b0;
      b_resp    <= RespOkay;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_resp    <= RespOkay;
      wr_pulse  <= '0;
    end else begin
      wr_pulse <= '0;
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        b_valid  <= 1'b1;
        b_resp   <= wr_resp;
        wr_pulse <= wr_sel;
      end else begin
        if (aw_valid && aw_ready) begin
          aw_held   <= 1'b1;
          aw_addr_q <= aw_addr;
        end
        if (w_valid && w_ready) begin
          w_held   <= 1'b1;
          w_data_q <= w_data;
          w_strb_q <= w_strb;
        end
        if (b_valid && b_ready) begin
          b_valid <= 1'b0;
        end
      end

      if (ar_valid && ar_ready) begin
        r_valid <= 1'b1;
        r_data  <= rd_data;
        r_resp  <= rd_resp;
      end else if (r_valid && r_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_axi_lite_regs.sv
// Directed bench for axi_lite_regs: a vector table of single transactions plus
// hand-written sequences for holds, back-pressure, read/commit overlap and reset.
module tb_axi_lite_regs;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 16;
  localparam logic [NR-1:0] RO = 16'h0004;
  localparam logic [NR*DW-1:0] RV =
      512'h12345678 | (512'hFFFFFFFF << 64) | (512'hCAFE0005 << 160);
  localparam logic [NR*DW-1:0] RST_IMG = 512'h12345678 | (512'hCAFE0005 << 160);

  logic clk = 1'b0;
  logic rst;
  logic aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic ar_valid, ar_ready, r_valid, r_ready;
  logic [AW-1:0] aw_addr, ar_addr;
  logic [2:0] aw_prot, ar_prot;
  logic [DW-1:0] w_data, r_data;
  logic [DW/8-1:0] w_strb;
  logic [1:0] b_resp, r_resp;
  logic [NR*DW-1:0] reg_q, ro_in;
  logic [NR-1:0] wr_pulse;

  always #5 clk = ~clk;

  axi_lite_regs #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .rst(rst),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_prot(aw_prot),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_prot(ar_prot),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .reg_q(reg_q), .ro_in(ro_in), .wr_pulse(wr_pulse)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_img [NR];

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] exp;
    logic [15:0] pulse;
  } vec_t;
  vec_t vecs [15];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] pack_img();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = exp_img[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] strb, output logic [1:0] resp,
                          output logic [NR-1:0] pulse, output logic [NR-1:0] pulse_after,
                          output int lat);
    logic aw_done, w_done;
    int n;
    aw_valid = 1'b1; aw_addr = addr; w_valid = 1'b1; w_data = data; w_strb = strb;
    n = 0;
    while ((aw_valid || w_valid) && n < 20) begin
      aw_done = aw_ready; w_done = w_ready;
      tick();
      if (aw_done) aw_valid = 1'b0;
      if (w_done) w_valid = 1'b0;
      n++;
    end
    aw_valid = 1'b0; w_valid = 1'b0;
    lat = 0;
    while (!b_valid && lat < 20) begin
      tick();
      lat++;
    end
    resp = b_resp;
    pulse = wr_pulse;
    tick();
    pulse_after = wr_pulse;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                         output logic [1:0] resp, output int lat);
    int n;
    ar_valid = 1'b1; ar_addr = addr;
    n = 0;
    while (ar_valid && n < 20) begin
      if (ar_ready) begin
        tick();
        ar_valid = 1'b0;
      end else begin
        tick();
      end
      n++;
    end
    ar_valid = 1'b0;
    lat = 0;
    while (!r_valid && lat < 20) begin
      tick();
      lat++;
    end
    data = r_data;
    resp = r_resp;
    tick();
  endtask

  initial begin
    logic [1:0] resp;
    logic [DW-1:0] data;
    logic [NR-1:0] pulse, pulse_after;
    int lat;

    vecs[0]  = '{1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 2'b00, 32'hDEADBEEF, 16'h0002};
    vecs[1]  = '{1'b0, 12'h004, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 16'h0000};
    vecs[2]  = '{1'b1, 12'h004, 32'h11223344, 4'h5, 2'b00, 32'hDE22BE44, 16'h0002};
    vecs[3]  = '{1'b0, 12'h004, 32'h0,        4'h0, 2'b00, 32'hDE22BE44, 16'h0000};
    vecs[4]  = '{1'b1, 12'h040, 32'h99999999, 4'hF, 2'b11, 32'h0,        16'h0000};
    vecs[5]  = '{1'b0, 12'h040, 32'h0,        4'h0, 2'b11, 32'h0,        16'h0000};
    vecs[6]  = '{1'b0, 12'h008, 32'h0,        4'h0, 2'b00, 32'hA5A5A5A5, 16'h0000};
    vecs[7]  = '{1'b1, 12'h008, 32'h12121212, 4'hF, 2'b10, 32'h0,        16'h0000};
    vecs[8]  = '{1'b0, 12'h000, 32'h0,        4'h0, 2'b00, 32'h12345678, 16'h0000};
    vecs[9]  = '{1'b1, 12'h000, 32'hAB000000, 4'h8, 2'b00, 32'hAB345678, 16'h0001};
    vecs[10] = '{1'b0, 12'h000, 32'h0,        4'h0, 2'b00, 32'hAB345678, 16'h0000};
    vecs[11] = '{1'b0, 12'h003, 32'h0,        4'h0, 2'b00, 32'hAB345678, 16'h0000};
    vecs[12] = '{1'b1, 12'h03C, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h0,        16'h8000};
    vecs[13] = '{1'b0, 12'h03C, 32'h0,        4'h0, 2'b00, 32'h0,        16'h0000};
    vecs[14] = '{1'b0, 12'h014, 32'h0,        4'h0, 2'b00, 32'hCAFE0005, 16'h0000};

    for (int i = 0; i < NR; i++) exp_img[i] = RST_IMG[i*DW +: DW];

    rst = 1'b1;
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    aw_addr = '0; ar_addr = '0; aw_prot = 3'b010; ar_prot = 3'b101;
    w_data = '0; w_strb = '0; b_ready = 1'b1; r_ready = 1'b1;
    ro_in = 512'h0BAD0BAD | (512'hA5A5A5A5 << 64);
    repeat (3) tick();

    check("rst_aw_ready", aw_ready, 1);
    check("rst_w_ready", w_ready, 1);
    check("rst_ar_ready", ar_ready, 1);
    check("rst_b_valid", b_valid, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_resps", {b_resp, r_resp}, 0);
    check("rst_r_data", r_data, 0);
    check("rst_wr_pulse", wr_pulse, 0);
    check("rst_reg_q", reg_q, RST_IMG);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, pulse, pulse_after, lat);
        check($sformatf("v%0d_b_resp", i), resp, vecs[i].resp);
        check($sformatf("v%0d_b_latency", i), lat, 1);
        check($sformatf("v%0d_wr_pulse", i), pulse, vecs[i].pulse);
        check($sformatf("v%0d_pulse_clear", i), pulse_after, 0);
        check($sformatf("v%0d_b_cleared", i), b_valid, 0);
        if (vecs[i].resp == 2'b00) exp_img[vecs[i].addr[5:2]] = vecs[i].exp;
      end else begin
        do_read(vecs[i].addr, data, resp, lat);
        check($sformatf("v%0d_r_resp", i), resp, vecs[i].resp);
        check($sformatf("v%0d_r_data", i), data, vecs[i].exp);
        check($sformatf("v%0d_r_latency", i), lat, 0);
      end
      check($sformatf("v%0d_reg_q", i), reg_q, pack_img());
    end

    // W leads AW by three cycles, then B back-pressure absorbs one more AW/W pair.
    b_ready = 1'b0;
    w_valid = 1'b1; w_data = 32'h00000077; w_strb = 4'hF;
    tick();
    w_valid = 1'b0;
    check("w_early_ready", w_ready, 0);
    repeat (2) begin
      tick();
      check("w_early_ready", w_ready, 0);
    end
    aw_valid = 1'b1; aw_addr = 12'h010;
    tick();
    aw_valid = 1'b0;
    check("aw_late_ready", aw_ready, 0);
    check("b_before_commit", b_valid, 0);
    tick();
    check("b_after_commit", b_valid, 1);
    check("b_resp_commit", b_resp, 2'b00);
    check("ready_after_commit", {aw_ready, w_ready}, 2'b11);
    check("pulse_reg4", wr_pulse, 16'h0010);
    aw_valid = 1'b1; aw_addr = 12'h014; w_valid = 1'b1; w_data = 32'h00000055;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    repeat (4) begin
      check("b_stable", {b_valid, b_resp}, 3'b100);
      check("second_beats_stall", {aw_ready, w_ready}, 2'b00);
      tick();
    end
    b_ready = 1'b1;
    tick();
    check("b_handshake_clears", b_valid, 0);
    tick();
    check("second_commit", {b_valid, b_resp}, 3'b100);
    exp_img[4] = 32'h00000077;
    exp_img[5] = 32'h00000055;
    check("reg_q_after_pair", reg_q, pack_img());
    tick();
    check("second_b_cleared", b_valid, 0);

    // Read of reg 3 lands in the same cycle as its commit.
    aw_valid = 1'b1; w_valid = 1'b1; aw_addr = 12'h00C; w_data = 32'h5; w_strb = 4'hF;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    ar_valid = 1'b1; ar_addr = 12'h00C;
    tick();
    ar_valid = 1'b0;
    check("overlap_r_valid", r_valid, 1);
    check("overlap_old_data", r_data, 32'h0);
    check("overlap_b_valid", b_valid, 1);
    exp_img[3] = 32'h5;
    check("overlap_reg_q", reg_q, pack_img());
    tick();
    do_read(12'h00C, data, resp, lat);
    check("overlap_new_data", data, 32'h5);

    // R back-pressure.
    r_ready = 1'b0;
    ar_valid = 1'b1; ar_addr = 12'h000;
    tick();
    ar_valid = 1'b0;
    repeat (3) begin
      check("r_stall", {r_valid, ar_ready}, 2'b10);
      check("r_stall_data", r_data, 32'hAB345678);
      tick();
    end
    r_ready = 1'b1;
    tick();
    check("r_released", r_valid, 0);

    // Reset with B pending discards it and restores the reset image.
    b_ready = 1'b0;
    aw_valid = 1'b1; w_valid = 1'b1; aw_addr = 12'h004; w_data = 32'h0; w_strb = 4'hF;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    tick();
    check("pending_b", b_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_b_valid", b_valid, 0);
    check("async_rst_pulse", wr_pulse, 0);
    check("async_rst_readies", {aw_ready, w_ready, ar_ready}, 3'b111);
    check("async_rst_reg_q", reg_q, RST_IMG);
    tick();
    rst = 1'b0;
    b_ready = 1'b1;
    tick();
    check("post_rst_b_valid", b_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
